mem_access_unit: RTL and testbench



---
 rtl/lc3_pkg.sv | 22 ++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared definitions for the LC-3 datapath memory stage:
//               datapath word width, memory-access FSM state encoding and
//               the default number of SRAM strobe cycles per access.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    localparam int WORD_W              = 16;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-side datapath stage. Holds MAR/MDR, sequences
//               multi-cycle SRAM read/write accesses and reports completion.
//   Ports:
//     Clk, Reset        - clock (rising edge), synchronous active-high reset
//     BUS               - datapath bus, source for MAR/MDR loads
//     Data_from_SRAM    - SRAM read data, captured into MDR on reads
//     LD_MAR, LD_MDR    - register load strobes (honoured only in IDLE)
//     Mem_Req, Mem_RW   - access request and direction (1 = write)
//     MAR, MDR          - address / data registers
//     Data_to_SRAM      - write data (always MDR)
//     Mem_CE_N/OE_N/WE_N- active-low SRAM strobes
//     Busy              - high whenever the FSM is not IDLE
//     Mem_Ready         - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import lc3_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
)
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WORD_W-1:0] BUS,
    input  logic [WORD_W-1:0] Data_from_SRAM,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Mem_Req,
    input  logic              Mem_RW,
    output logic [WORD_W-1:0] MAR,
    output logic [WORD_W-1:0] MDR,
    output logic [WORD_W-1:0] Data_to_SRAM,
    output logic              Mem_CE_N,
    output logic              Mem_OE_N,
    output logic              Mem_WE_N,
    output logic              Busy,
    output logic              Mem_Ready
);

    // A single wait cycle still needs a 1-bit counter so the logic stays legal.
    localparam int               CNT_W        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_count_load = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t        r_state;
    mem_state_t        w_next_state;
    logic [CNT_W-1:0]  r_count;
    logic [WORD_W-1:0] r_mar;
    logic [WORD_W-1:0] r_mdr;
    logic              w_count_zero;

    assign w_count_zero = (r_count == '0);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and strobe decode. Strobes depend on r_state only, so they
    // cannot glitch on request or bus inputs.
    always_comb begin
        w_next_state = r_state;
        Mem_CE_N     = 1'b1;
        Mem_OE_N     = 1'b1;
        Mem_WE_N     = 1'b1;
        Busy         = 1'b1;
        Mem_Ready    = 1'b0;
        case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (Mem_Req) begin
                    // Direction is latched by the choice of state.
                    w_next_state = Mem_RW ? WRITE : READ;
                end
            end
            READ: begin
                Mem_CE_N = 1'b0;
                Mem_OE_N = 1'b0;
                if (w_count_zero) begin
                    w_next_state = DONE;
                end
            end
            WRITE: begin
                Mem_CE_N = 1'b0;
                Mem_WE_N = 1'b0;
                if (w_count_zero) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                Mem_Ready    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registers and wait counter. Loads are accepted only in IDLE, which
    // freezes MAR/MDR for the whole transaction. A load coinciding with a
    // request lands at the same edge, so the access sees the new value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mar   <= '0;
            r_mdr   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (LD_MAR) begin
                        r_mar <= BUS;
                    end
                    if (LD_MDR) begin
                        r_mdr <= BUS;
                    end
                    if (Mem_Req) begin
                        r_count <= c_count_load;
                    end
                end
                READ: begin
                    if (w_count_zero) begin
                        r_mdr <= Data_from_SRAM;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                WRITE: begin
                    if (!w_count_zero) begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MAR          = r_mar;
    assign MDR          = r_mdr;
    assign Data_to_SRAM = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Two instances
//               (WAIT_CYCLES = 2 and 1) are exercised one at a time with
//               directed and random stimulus; expected transactions are
//               queued by the stimulus and checked by per-instance monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    typedef struct {
        int          inst;
        int          e0;         // edge at which the request is accepted
        bit          rw;
        logic [15:0] mar;
        logic [15:0] mdr_before;
        logic [15:0] mdr_after;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_s   [2];
    logic [15:0] sram_rd [2];
    logic [15:0] mar_o   [2];
    logic [15:0] mdr_o   [2];
    logic [15:0] dts_o   [2];
    logic        ld_mar_s[2];
    logic        ld_mdr_s[2];
    logic        req_s   [2];
    logic        rw_s    [2];
    logic        ce_o    [2];
    logic        oe_o    [2];
    logic        we_o    [2];
    logic        busy_o  [2];
    logic        rdy_o   [2];

    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    bit   started = 1'b0;
    exp_t q[$];

    // Reference model state
    logic [15:0] m_mar  [2];
    logic [15:0] m_mdr  [2];
    int          next_ok[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // SRAM contents: a fixed function of the address.
    function automatic logic [15:0] sram_f(input logic [15:0] a);
        if (a == 16'h3000) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int W = (k == 0) ? 2 : 1;

        mem_access_unit #(.WAIT_CYCLES(W)) u_dut (
            .Clk            (clk),
            .Reset          (rst),
            .BUS            (bus_s[k]),
            .Data_from_SRAM (sram_rd[k]),
            .LD_MAR         (ld_mar_s[k]),
            .LD_MDR         (ld_mdr_s[k]),
            .Mem_Req        (req_s[k]),
            .Mem_RW         (rw_s[k]),
            .MAR            (mar_o[k]),
            .MDR            (mdr_o[k]),
            .Data_to_SRAM   (dts_o[k]),
            .Mem_CE_N       (ce_o[k]),
            .Mem_OE_N       (oe_o[k]),
            .Mem_WE_N       (we_o[k]),
            .Busy           (busy_o[k]),
            .Mem_Ready      (rdy_o[k])
        );

        // SRAM drives valid data only while selected for read.
        assign sram_rd[k] = (!ce_o[k] && !oe_o[k]) ? sram_f(mar_o[k]) : 16'hDEAD;

        // Monitor: {Busy, CE_N, OE_N, WE_N, Mem_Ready} per cycle.
        always @(negedge clk) begin
            exp_t e;
            int   ph;
            if (started && !rst) begin
                if (q.size() > 0 && q[0].inst == k && q[0].e0 <= cyc) begin
                    e  = q[0];
                    ph = cyc - e.e0;
                    check("mar_frozen", 32'(mar_o[k]), 32'(e.mar));
                    if (ph < W) begin
                        check("strobes_active", 32'({busy_o[k], ce_o[k], oe_o[k], we_o[k], rdy_o[k]}),
                              32'({1'b1, 1'b0, e.rw, ~e.rw, 1'b0}));
                        check("mdr_frozen", 32'(mdr_o[k]), 32'(e.mdr_before));
                        check("data_to_sram", 32'(dts_o[k]), 32'(e.mdr_before));
                    end else begin
                        check("done_strobes", 32'({busy_o[k], ce_o[k], oe_o[k], we_o[k], rdy_o[k]}),
                              32'(5'b11111));
                        check("mdr_result", 32'(mdr_o[k]), 32'(e.mdr_after));
                        void'(q.pop_front());
                    end
                end else begin
                    check("idle_strobes", 32'({busy_o[k], ce_o[k], oe_o[k], we_o[k], rdy_o[k]}),
                          32'(5'b01110));
                end
            end
        end
    end

    // One stimulus cycle on instance k; the model decides whether the
    // block is idle at the sampling edge and what it should do.
    task automatic drive(input int k, input bit lm, input bit ld, input bit rq,
                         input bit rw, input logic [15:0] b);
        int   e;
        exp_t x;
        e = cyc + 1;
        if (e >= next_ok[k]) begin
            if (lm) m_mar[k] = b;
            if (ld) m_mdr[k] = b;
            if (rq) begin
                x.inst       = k;
                x.e0         = e;
                x.rw         = rw;
                x.mar        = m_mar[k];
                x.mdr_before = m_mdr[k];
                x.mdr_after  = rw ? m_mdr[k] : sram_f(m_mar[k]);
                m_mdr[k]     = x.mdr_after;
                q.push_back(x);
                next_ok[k]   = e + wc(k) + 2;
            end
        end
        bus_s[k]    = b;
        ld_mar_s[k] = lm;
        ld_mdr_s[k] = ld;
        req_s[k]    = rq;
        rw_s[k]     = rw;
        @(posedge clk);
        #1;
        if (cyc + 1 >= next_ok[k]) begin
            check("idle_mar", 32'(mar_o[k]), 32'(m_mar[k]));
            check("idle_mdr", 32'(mdr_o[k]), 32'(m_mdr[k]));
        end
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        for (int k = 0; k < 2; k++) begin
            m_mar[k] = '0; m_mdr[k] = '0; next_ok[k] = 0;
            bus_s[k] = '0; ld_mar_s[k] = 1'b0; ld_mdr_s[k] = 1'b0;
            req_s[k] = 1'b0; rw_s[k] = 1'b0;
        end
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("reset_mar", 32'(mar_o[k]), 32'h0);
            check("reset_mdr", 32'(mdr_o[k]), 32'h0);
            check("reset_strobes", 32'({busy_o[k], ce_o[k], oe_o[k], we_o[k], rdy_o[k]}), 32'(5'b01110));
        end
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            idle(k, 1);
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic random_phase(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            drive(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 65535)));
        end
        drain(k);
    endtask

    initial begin
        do_reset(2);
        started = 1'b1;

        for (int k = 0; k < 2; k++) begin
            // Directed read: MAR=0x3000, SRAM returns 0xBEEF
            drive(k, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3000);
            drive(k, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            drain(k);
            idle(k, 2);
            // Directed write: MAR=0x0042, LD_MDR 0x1234 with the request
            drive(k, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
            drive(k, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
            drain(k);
            idle(k, 2);
            // Lockout: loads and requests during busy and DONE are ignored
            drive(k, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
            drive(k, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            for (int i = 0; i < wc(k) + 1; i++) drive(k, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
            drain(k);
            idle(k, 2);
            // Back-to-back reads with Mem_Req held high
            drive(k, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200);
            for (int i = 0; i < wc(k) + 3; i++) drive(k, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            drain(k);
            idle(k, 2);
            random_phase(k, 60);
            idle(k, 2);
        end

        // Reset in the middle of a read
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300);
        drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        idle(0, 1);
        do_reset(1);
        idle(0, 3);
        random_phase(0, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
